// File: rtl/vc_fifo_bank.sv
// vc_fifo_bank: four independent circular FIFOs (virtual channels) sharing
// one push port and one registered pop port.
// Optional feature: define VC_ALMOST_FULL_EN to drive the almost_full_vchannel*
// flags from an occupancy threshold. When it is undefined they are tied low.
module vc_fifo_bank #(
    parameter int DATA_WIDTH = 6,
    parameter int DEPTH      = 4,
    parameter int AF_THRESH  = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enb,
    input  logic                  push,
    input  logic [1:0]            push_vc,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  pop,
    input  logic [1:0]            pop_vc,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  valid_out,
    output logic                  empty_vchannel0,
    output logic                  empty_vchannel1,
    output logic                  empty_vchannel2,
    output logic                  empty_vchannel3,
    output logic                  full_vchannel0,
    output logic                  full_vchannel1,
    output logic                  full_vchannel2,
    output logic                  full_vchannel3,
    output logic                  almost_full_vchannel0,
    output logic                  almost_full_vchannel1,
    output logic                  almost_full_vchannel2,
    output logic                  almost_full_vchannel3,
    output logic                  overflow_err,
    output logic                  underflow_err
);
    localparam int NVC = 4;
    localparam int PW  = $clog2(DEPTH);
    localparam int CW  = PW + 1;

    // Parameter sanity: pointer wrap relies on DEPTH being a power of two.
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("vc_fifo_bank: DEPTH must be a power of two >= 2");
    end
    if (AF_THRESH < 1 || AF_THRESH > DEPTH) begin : g_bad_af
        $error("vc_fifo_bank: AF_THRESH must be in 1..DEPTH");
    end

    logic [NVC-1:0][PW-1:0] wr_ptr;
    logic [NVC-1:0][PW-1:0] rd_ptr;
    logic [NVC-1:0][CW-1:0] occ;
    logic [DATA_WIDTH-1:0]  mem [NVC][DEPTH];

    logic [NVC-1:0] empty, full, af;
    logic [NVC-1:0] push_sel, push_ok, pop_ok;

    for (genvar v = 0; v < NVC; v++) begin : g_vc
        assign empty[v]    = (occ[v] == '0);
        assign full[v]     = (occ[v] == CW'(DEPTH));
        assign push_sel[v] = enb & push & (push_vc == 2'(v));
        // A pop only succeeds on a non-empty channel; there is no bypass of
        // a same-cycle push into an empty channel.
        assign pop_ok[v]   = enb & pop & (pop_vc == 2'(v)) & ~empty[v];
        // A full channel still takes a push when it is popped in the same cycle.
        assign push_ok[v]  = push_sel[v] & (~full[v] | pop_ok[v]);

`ifdef VC_ALMOST_FULL_EN
        assign af[v] = ({{(32-CW){1'b0}}, occ[v]} >= AF_THRESH);
`else
        assign af[v] = 1'b0;
`endif

        // Per-channel pointer and occupancy bookkeeping.
        always_ff @(posedge clk) begin
            if (rst) begin
                wr_ptr[v] <= '0;
                rd_ptr[v] <= '0;
                occ[v]    <= '0;
            end else begin
                if (push_ok[v]) wr_ptr[v] <= wr_ptr[v] + 1'b1;
                if (pop_ok[v])  rd_ptr[v] <= rd_ptr[v] + 1'b1;
                case ({push_ok[v], pop_ok[v]})
                    2'b10:   occ[v] <= occ[v] + 1'b1;
                    2'b01:   occ[v] <= occ[v] - 1'b1;
                    default: occ[v] <= occ[v];
                endcase
            end
        end
    end

    // Storage write; no reset needed since pointers gate every read.
    always_ff @(posedge clk) begin
        if (push_ok[push_vc]) mem[push_vc][wr_ptr[push_vc]] <= data_in;
    end

    // Registered read port: one valid pulse per accepted pop, data held otherwise.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_out <= 1'b0;
            data_out  <= '0;
        end else begin
            valid_out <= |pop_ok;
            if (|pop_ok) data_out <= mem[pop_vc][rd_ptr[pop_vc]];
        end
    end

    // Sticky error flags, cleared only by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            overflow_err  <= 1'b0;
            underflow_err <= 1'b0;
        end else begin
            if (enb && push && full[push_vc] && !pop_ok[push_vc]) overflow_err <= 1'b1;
            if (enb && pop && empty[pop_vc]) underflow_err <= 1'b1;
        end
    end

    assign empty_vchannel0       = empty[0];
    assign empty_vchannel1       = empty[1];
    assign empty_vchannel2       = empty[2];
    assign empty_vchannel3       = empty[3];
    assign full_vchannel0        = full[0];
    assign full_vchannel1        = full[1];
    assign full_vchannel2        = full[2];
    assign full_vchannel3        = full[3];
    assign almost_full_vchannel0 = af[0];
    assign almost_full_vchannel1 = af[1];
    assign almost_full_vchannel2 = af[2];
    assign almost_full_vchannel3 = af[3];
endmodule
